// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, with round keys read
// combinationally from an external key table addressed by rk_idx.
module aes_dec_round_ctrl #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [KIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;
  typedef logic [15:0][7:0] blk_t;  // byte k (row k%4, col k/4) sits at index 15-k

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic blk_t inv_shift_rows(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[15-(r+4*c)] = s[15-(r+4*((c+4-r)%4))];
    return o;
  endfunction

  function automatic blk_t inv_sub_bytes(input blk_t s);
    blk_t o;
    for (int k = 0; k < 16; k++) o[k] = inv_sbox(s[k]);
    return o;
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[15-4*c];
      a1 = s[14-4*c];
      a2 = s[13-4*c];
      a3 = s[12-4*c];
      o[15-4*c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[14-4*c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[13-4*c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[12-4*c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_e              state_q, state_d;
  logic [127:0]        st_q, st_d;
  logic [127:0]        out_q, out_d;
  logic [KIDX_W-1:0]   rnd_q, rnd_d;
  blk_t                sub_key;

  // ROUND and FINAL share one shift/sub/add-key stage; only ROUND adds InvMixColumns.
  assign sub_key = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_data;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == ROUND) || (state_q == FINAL);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

  always_comb begin
    unique case (state_q)
      IDLE:    rk_idx = KIDX_W'(NR);
      ROUND:   rk_idx = rnd_q;
      default: rk_idx = '0;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_data ^ rk_data;
          rnd_d   = KIDX_W'(NR - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d  = inv_mix_columns(sub_key);
        rnd_d = rnd_q - KIDX_W'(1);
        if (rnd_q == KIDX_W'(1)) state_d = FINAL;
      end
      FINAL: begin
        st_d    = sub_key;
        out_d   = sub_key;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Directed bench for aes_dec_round_ctrl: cycle-level behavioural model compared every cycle,
// plus FIPS-197 literal vectors for latency, backpressure, back-to-back and reset cases.
module tb_aes_dec_round_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_data, out_data;
  logic [3:0]   rk_idx;

  logic [127:0] rk_tab [NR+1];
  logic [7:0]   sbox   [256];
  logic [7:0]   isbox  [256];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int           hs_cyc [$];
  logic [127:0] hs_dat [$];

  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_dec_round_ctrl #(.NR(NR), .KIDX_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign rk_data = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference AES arithmetic ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] m_inv(input logic [7:0] x);
    for (int y = 1; y < 256; y++)
      if (m_mul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      s = m_inv(8'(x));
      sbox[x] = s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
        rcon = m_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   base [4];
    logic [127:0] v;
    base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    v = ct ^ rk_tab[NR];
    for (int rd = NR - 1; rd >= 0; rd--) begin
      for (int k = 0; k < 16; k++) s[k] = v[127-8*k -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = isbox[s[r+4*((c-r+4)%4)]];
      for (int k = 0; k < 16; k++) v[127-8*k -: 8] = t[k];
      v = v ^ rk_tab[rd];
      if (rd != 0) begin
        for (int k = 0; k < 16; k++) s[k] = v[127-8*k -: 8];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            t[4*c+r] = 8'h00;
            for (int j = 0; j < 4; j++) t[4*c+r] = t[4*c+r] ^ m_mul(s[4*c+j], base[(j-r+4)%4]);
          end
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = t[k];
      end
    end
    return v;
  endfunction

  // ---------------- cycle model and per-cycle compare ----------------
  // m_age: 0 = waiting for a block, 1..NR = rounds in progress, NR+1 = result held.
  initial begin
    bit           m_known;
    int           m_age;
    logic [127:0] m_pt, m_last;
    m_known = 0; m_age = 0; m_pt = '0; m_last = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_known) begin
        check("cmp_in_ready",  in_ready,  128'(m_age == 0));
        check("cmp_busy",      busy,      128'(m_age >= 1 && m_age <= NR));
        check("cmp_out_valid", out_valid, 128'(m_age == NR + 1));
        check("cmp_rk_idx",    rk_idx,    128'((m_age == 0) ? NR : (m_age <= NR) ? NR - m_age : 0));
        check("cmp_out_data",  out_data,  m_last);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) begin
        hs_cyc.push_back(cyc);
        hs_dat.push_back(out_data);
      end
      if (reset === 1'b1) begin
        m_known = 1; m_age = 0; m_last = '0;
      end else if (m_known) begin
        if (m_age == 0) begin
          if (in_valid) begin
            m_age = 1;
            m_pt  = ref_dec(in_data);
          end
        end else if (m_age <= NR) begin
          m_age++;
          if (m_age == NR + 1) m_last = m_pt;
        end else if (out_ready) begin
          m_age = 0;
        end
      end
    end
  end

  task automatic run_block(input logic [127:0] ct, output logic [127:0] got, output int lat);
    int i;
    got = '0;
    in_valid = 1'b1;
    in_data  = ct;
    i = 0;
    while (!in_ready && i < 50) begin tick(); i++; end
    check("accept_timeout", in_ready, 128'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check("result_timeout", out_valid, 128'd1);
    got = out_data;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got;
    logic [127:0] blk [3];
    int lat, n0, early, busy_n, i;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    build_sbox();
    expand_key(KEY_C1);
    check("pin_sbox0",      128'(sbox[0]), 128'h63);
    check("pin_rk10_c1",    rk_tab[NR], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("pin_ref_dec_c1", ref_dec(CT_C1), PT_C1);
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready",  in_ready,  128'd1);
    check("rst_out_valid", out_valid, 128'd0);
    check("rst_busy",      busy,      128'd0);
    check("rst_out_data",  out_data,  128'd0);
    check("rst_rk_idx",    rk_idx,    128'd10);

    // C.1 with latency, key-index sequence and busy duration.
    in_valid = 1'b1; in_data = CT_C1; early = 0; busy_n = 0;
    for (int c = 0; c <= NR; c++) begin
      check("rk_seq", rk_idx, 128'(NR - c));
      early  += int'(out_valid);
      busy_n += int'(busy);
      tick();
      if (c == 0) in_valid = 1'b0;
    end
    check("lat_no_early_valid", 128'(early), 128'd0);
    check("lat_valid_at_11",    out_valid, 128'd1);
    check("busy_cycles",        128'(busy_n), 128'd10);
    check("c1_plaintext",       out_data, PT_C1);
    tick();

    // Backpressure in DONE with ignored in_valid pulses.
    out_ready = 1'b0; in_valid = 1'b1; in_data = CT_C1;
    tick();
    in_valid = 1'b0;
    i = 0;
    while (!out_valid && i < 50) begin tick(); i++; end
    check("bp_reach_done", out_valid, 128'd1);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      check("bp_valid_hold", out_valid, 128'd1);
      check("bp_data_hold",  out_data,  PT_C1);
      check("bp_in_ready",   in_ready,  128'd0);
      tick();
    end
    n0 = hs_dat.size();
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_release_idle",   in_ready, 128'd1);
    check("bp_release_nobusy", busy,     128'd0);
    check("bp_one_handshake",  128'(hs_dat.size() - n0), 128'd1);
    run_block(CT_C1, got, lat);
    check("bp_next_plaintext", got, PT_C1);
    check("bp_next_latency",   128'(lat), 128'd11);

    // Back-to-back with in_valid held high.
    blk[0] = CT_C1;
    blk[1] = {$urandom, $urandom, $urandom, $urandom};
    blk[2] = {$urandom, $urandom, $urandom, $urandom};
    n0 = hs_dat.size();
    i = 0;
    in_valid = 1'b1; in_data = blk[0];
    for (int c = 0; c < 200 && i < 3; c++) begin
      if (in_ready) begin
        tick();
        i++;
        if (i < 3) in_data = blk[i]; else in_valid = 1'b0;
      end else tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 100 && hs_dat.size() < n0 + 3; c++) tick();
    check("b2b_count", 128'(hs_dat.size() - n0), 128'd3);
    if (hs_dat.size() >= n0 + 3) begin
      check("b2b_pt0",      hs_dat[n0], PT_C1);
      check("b2b_pt1",      hs_dat[n0+1], ref_dec(blk[1]));
      check("b2b_spacing1", 128'(hs_cyc[n0+1] - hs_cyc[n0]), 128'd12);
      check("b2b_spacing2", 128'(hs_cyc[n0+2] - hs_cyc[n0+1]), 128'd12);
    end

    // Reset on the 5th ROUND cycle.
    in_valid = 1'b1; in_data = CT_C1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_in_ready",  in_ready,  128'd1);
    check("rstmid_out_valid", out_valid, 128'd0);
    check("rstmid_busy",      busy,      128'd0);
    n0 = hs_dat.size();
    for (int c = 0; c < 15; c++) tick();
    check("rstmid_no_output", 128'(hs_dat.size() - n0), 128'd0);
    run_block(CT_C1, got, lat);
    check("rstmid_next_pt", got, PT_C1);

    // All-zero keys and ciphertext, then FIPS-197 appendix B.
    for (int r = 0; r <= NR; r++) rk_tab[r] = '0;
    run_block(128'd0, got, lat);
    check("zero_vs_model", got, ref_dec(128'd0));
    expand_key(KEY_B);
    check("pin_rk10_b", rk_tab[NR], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_block(CT_B, got, lat);
    check("b_plaintext", got, PT_B);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
